// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline boundary register: default widths,
// the bubble instruction and the sticky-flush state encoding.
package pipe_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pend_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of the stage's control, fetch-side and decode-side signals.
// master: the side driving fetch data and controls; slave: the stage itself.
interface pipe_stage_reg_if #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned INSTR_W = pipe_pkg::INSTR_W,
  parameter int unsigned PC_W    = pipe_pkg::PC_W,
  parameter int unsigned CNT_W   = 16
);

  logic                     hold;
  logic                     flush;
  logic [LANES-1:0]         lane_kill;
  logic [LANES-1:0]         in_valid;
  logic [LANES*INSTR_W-1:0] in_instr;
  logic [LANES*PC_W-1:0]    in_pc4;
  logic [LANES-1:0]         out_valid;
  logic [LANES*INSTR_W-1:0] out_instr;
  logic [LANES*PC_W-1:0]    out_pc4;
  logic                     flush_pending;
  logic [CNT_W-1:0]         stall_cnt;
  logic [CNT_W-1:0]         flush_cnt;

  modport master (
    output hold, flush, lane_kill, in_valid, in_instr, in_pc4,
    input  out_valid, out_instr, out_pc4, flush_pending, stall_cnt, flush_cnt
  );

  modport slave (
    input  hold, flush, lane_kill, in_valid, in_instr, in_pc4,
    output out_valid, out_instr, out_pc4, flush_pending, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_stage_reg_lane.sv
// One instruction slot of the boundary register: valid, instruction, PC+4.
// A bubble load clears valid and forces the payload to bubble values.
module pipe_lane_reg #(
  parameter int unsigned INSTR_W = pipe_pkg::INSTR_W,
  parameter int unsigned PC_W    = pipe_pkg::PC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc4,
  output logic               q_valid,
  output logic [INSTR_W-1:0] q_instr,
  output logic [PC_W-1:0]    q_pc4
);

  import pipe_pkg::*;

  // Slot register: hold when load_en=0, otherwise load data or a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_instr <= INSTR_W'(NOP_INSTR);
      q_pc4   <= '0;
    end else if (load_en) begin
      if (bubble) begin
        q_valid <= 1'b0;
        q_instr <= INSTR_W'(NOP_INSTR);
        q_pc4   <= '0;
      end else begin
        q_valid <= 1'b1;
        q_instr <= d_instr;
        q_pc4   <= d_pc4;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// IF/ID-style multi-lane pipeline boundary register with sticky flush
// (a flush seen during hold is applied on the first un-held edge) and
// per-lane kill. Optional performance counters under PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned INSTR_W = pipe_pkg::INSTR_W,
  parameter int unsigned PC_W    = pipe_pkg::PC_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic           clk,
  input  logic           reset,
  pipe_stage_reg_if.slave bus
);

  import pipe_pkg::*;

  pend_state_e state_q, state_d;
  logic        flush_all;

  logic               lane_valid [LANES];
  logic [INSTR_W-1:0] lane_instr [LANES];
  logic [PC_W-1:0]    lane_pc4   [LANES];

  // Pending-flush state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state and full-flush decode: a direct flush or a remembered one
  // bubbles every lane on the first edge without hold.
  always_comb begin
    state_d   = state_q;
    flush_all = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.hold && bus.flush) state_d = PEND;
        else if (!bus.hold && bus.flush) flush_all = 1'b1;
      end
      PEND: begin
        if (!bus.hold) begin
          state_d   = RUN;
          flush_all = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.flush_pending = (state_q == PEND);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pipe_lane_reg #(
      .INSTR_W(INSTR_W),
      .PC_W   (PC_W)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load_en(!bus.hold),
      .bubble (flush_all | bus.lane_kill[i] | !bus.in_valid[i]),
      .d_instr(bus.in_instr[i*INSTR_W +: INSTR_W]),
      .d_pc4  (bus.in_pc4[i*PC_W +: PC_W]),
      .q_valid(lane_valid[i]),
      .q_instr(lane_instr[i]),
      .q_pc4  (lane_pc4[i])
    );
  end

  // Pack per-lane registers onto the decode-side buses.
  always_comb begin
    bus.out_valid = '0;
    bus.out_instr = '0;
    bus.out_pc4   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      bus.out_valid[i]                   = lane_valid[i];
      bus.out_instr[i*INSTR_W +: INSTR_W] = lane_instr[i];
      bus.out_pc4[i*PC_W +: PC_W]         = lane_pc4[i];
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating stall and applied-flush counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (bus.hold && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_all && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = CNT_W'(0);
  assign bus.flush_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (LANES=2, CNT_W=4): directed
// vector table, asynchronous reset and counter saturation sequences, then
// random traffic against a behavioural model. Counter expectations follow
// PIPE_STAGE_PERF_EN.
module tb_pipe_stage_reg;

  localparam int unsigned LANES = 2;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.LANES(LANES), .INSTR_W(32), .PC_W(32), .CNT_W(CNT_W)) bus ();

  pipe_stage_reg #(
    .LANES  (LANES),
    .INSTR_W(32),
    .PC_W   (32),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural model state
  bit          m_v [2];
  logic [31:0] m_i [2];
  logic [31:0] m_p [2];
  bit          m_pend;
  int          m_st;
  int          m_fc;

  typedef struct {
    bit          h;
    bit          f;
    logic [1:0]  k;
    logic [1:0]  v;
    logic [31:0] i0, i1, p0, p1;
    logic [1:0]  ev;
    logic [31:0] ei0, ei1, ep0, ep1;
    bit          epend;
    int          est;
    int          efc;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(bit h, bit f, logic [1:0] k, logic [1:0] v,
                              logic [31:0] i0, logic [31:0] i1,
                              logic [31:0] p0, logic [31:0] p1,
                              logic [1:0] ev, logic [31:0] ei0, logic [31:0] ei1,
                              logic [31:0] ep0, logic [31:0] ep1,
                              bit epend, int est, int efc);
    vec_t r;
    r.h = h; r.f = f; r.k = k; r.v = v;
    r.i0 = i0; r.i1 = i1; r.p0 = p0; r.p1 = p1;
    r.ev = ev; r.ei0 = ei0; r.ei1 = ei1; r.ep0 = ep0; r.ep1 = ep1;
    r.epend = epend; r.est = est; r.efc = efc;
    return r;
  endfunction

  function automatic int exp_cnt(int c);
`ifdef PIPE_STAGE_PERF_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_v[l] = 1'b0; m_i[l] = '0; m_p[l] = '0;
    end
    m_pend = 1'b0; m_st = 0; m_fc = 0;
  endtask

  // One clock edge of the stage as described by its priority rules.
  task automatic model_step(input bit h, input bit f, input logic [1:0] k, input logic [1:0] v,
                            input logic [31:0] i0, input logic [31:0] i1,
                            input logic [31:0] p0, input logic [31:0] p1);
    logic [31:0] ii [2];
    logic [31:0] pp [2];
    ii[0] = i0; ii[1] = i1; pp[0] = p0; pp[1] = p1;
    if (h) begin
      if (f) m_pend = 1'b1;
      if (m_st < CMAX) m_st++;
    end else if (f || m_pend) begin
      for (int l = 0; l < 2; l++) begin
        m_v[l] = 1'b0; m_i[l] = '0; m_p[l] = '0;
      end
      m_pend = 1'b0;
      if (m_fc < CMAX) m_fc++;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (k[l] || !v[l]) begin
          m_v[l] = 1'b0; m_i[l] = '0; m_p[l] = '0;
        end else begin
          m_v[l] = 1'b1; m_i[l] = ii[l]; m_p[l] = pp[l];
        end
      end
    end
  endtask

  task automatic drive(input bit h, input bit f, input logic [1:0] k, input logic [1:0] v,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0, input logic [31:0] p1);
    bus.hold      = h;
    bus.flush     = f;
    bus.lane_kill = k;
    bus.in_valid  = v;
    bus.in_instr  = {i1, i0};
    bus.in_pc4    = {p1, p0};
    @(posedge clk);
    #1;
    model_step(h, f, k, v, i0, i1, p0, p1);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'({m_v[1], m_v[0]}));
    chk({tag, ".instr0"}, 64'(bus.out_instr[31:0]), 64'(m_i[0]));
    chk({tag, ".instr1"}, 64'(bus.out_instr[63:32]), 64'(m_i[1]));
    chk({tag, ".pc4_0"}, 64'(bus.out_pc4[31:0]), 64'(m_p[0]));
    chk({tag, ".pc4_1"}, 64'(bus.out_pc4[63:32]), 64'(m_p[1]));
    chk({tag, ".pending"}, 64'(bus.flush_pending), 64'(m_pend));
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(exp_cnt(m_st)));
    chk({tag, ".flush_cnt"}, 64'(bus.flush_cnt), 64'(exp_cnt(m_fc)));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, ".instr"}, 64'(bus.out_instr), 64'(0));
    chk({tag, ".pc4"}, 64'(bus.out_pc4), 64'(0));
    chk({tag, ".pending"}, 64'(bus.flush_pending), 64'(0));
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(0));
    chk({tag, ".flush_cnt"}, 64'(bus.flush_cnt), 64'(0));
  endtask

  initial begin
    bus.hold = 1'b0; bus.flush = 1'b0; bus.lane_kill = '0; bus.in_valid = '0;
    bus.in_instr = '0; bus.in_pc4 = '0;
    model_reset();

    //          h  f  kill   vin    i0            i1            p0      p1      ev     ei0           ei1           ep0     ep1     pend st fc
    tbl[0]  = mk(0, 0, 2'b00, 2'b11, 32'h20080005, 32'h20090003, 32'h4,  32'h8,  2'b11, 32'h20080005, 32'h20090003, 32'h4,  32'h8,  0, 0, 0);
    tbl[1]  = mk(1, 1, 2'b11, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 32'h100,32'h104,2'b11, 32'h20080005, 32'h20090003, 32'h4,  32'h8,  1, 1, 0);
    tbl[2]  = mk(1, 0, 2'b00, 2'b00, 32'h11111111, 32'h22222222, 32'h10, 32'h14, 2'b11, 32'h20080005, 32'h20090003, 32'h4,  32'h8,  1, 2, 0);
    tbl[3]  = mk(1, 0, 2'b00, 2'b11, 32'h11111111, 32'h22222222, 32'h10, 32'h14, 2'b11, 32'h20080005, 32'h20090003, 32'h4,  32'h8,  1, 3, 0);
    tbl[4]  = mk(0, 0, 2'b00, 2'b11, 32'h33333333, 32'h44444444, 32'h20, 32'h24, 2'b00, 32'h0,        32'h0,        32'h0,  32'h0,  0, 3, 1);
    tbl[5]  = mk(0, 0, 2'b10, 2'b11, 32'h8C220004, 32'h55555555, 32'h30, 32'h34, 2'b01, 32'h8C220004, 32'h0,        32'h30, 32'h0,  0, 3, 1);
    tbl[6]  = mk(0, 1, 2'b01, 2'b11, 32'h66666666, 32'h77777777, 32'h40, 32'h44, 2'b00, 32'h0,        32'h0,        32'h0,  32'h0,  0, 3, 2);
    tbl[7]  = mk(1, 1, 2'b00, 2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h48, 32'h4C, 2'b00, 32'h0,        32'h0,        32'h0,  32'h0,  1, 4, 2);
    tbl[8]  = mk(1, 1, 2'b00, 2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h48, 32'h4C, 2'b00, 32'h0,        32'h0,        32'h0,  32'h0,  1, 5, 2);
    tbl[9]  = mk(0, 0, 2'b00, 2'b11, 32'h88888888, 32'h99999999, 32'h50, 32'h54, 2'b00, 32'h0,        32'h0,        32'h0,  32'h0,  0, 5, 3);
    tbl[10] = mk(0, 0, 2'b00, 2'b11, 32'hAAAA0001, 32'hBBBB0002, 32'h60, 32'h64, 2'b11, 32'hAAAA0001, 32'hBBBB0002, 32'h60, 32'h64, 0, 5, 3);
    tbl[11] = mk(0, 0, 2'b00, 2'b10, 32'hCCCC0003, 32'hDDDD0004, 32'h70, 32'h74, 2'b10, 32'h0,        32'hDDDD0004, 32'h0,  32'h74, 0, 5, 3);
    tbl[12] = mk(0, 0, 2'b00, 2'b01, 32'h8C220004, 32'hEEEE0005, 32'h78, 32'h7C, 2'b01, 32'h8C220004, 32'h0,        32'h78, 32'h0,  0, 5, 3);

    // Reset state while reset is held low
    #12;
    check_cleared("reset0");
    reset = 1'b1;

    // Directed vectors
    foreach (tbl[n]) begin
      drive(tbl[n].h, tbl[n].f, tbl[n].k, tbl[n].v, tbl[n].i0, tbl[n].i1, tbl[n].p0, tbl[n].p1);
      chk($sformatf("vec%0d.valid", n), 64'(bus.out_valid), 64'(tbl[n].ev));
      chk($sformatf("vec%0d.instr0", n), 64'(bus.out_instr[31:0]), 64'(tbl[n].ei0));
      chk($sformatf("vec%0d.instr1", n), 64'(bus.out_instr[63:32]), 64'(tbl[n].ei1));
      chk($sformatf("vec%0d.pc4_0", n), 64'(bus.out_pc4[31:0]), 64'(tbl[n].ep0));
      chk($sformatf("vec%0d.pc4_1", n), 64'(bus.out_pc4[63:32]), 64'(tbl[n].ep1));
      chk($sformatf("vec%0d.pending", n), 64'(bus.flush_pending), 64'(tbl[n].epend));
      chk($sformatf("vec%0d.stall_cnt", n), 64'(bus.stall_cnt), 64'(exp_cnt(tbl[n].est)));
      chk($sformatf("vec%0d.flush_cnt", n), 64'(bus.flush_cnt), 64'(exp_cnt(tbl[n].efc)));
    end

    // Asynchronous reset mid-hold with a flush pending and lane0 loaded
    drive(1, 1, 2'b00, 2'b11, 32'h0BADF00D, 32'h0BADF00D, 32'h0, 32'h0);
    chk("prereset.pending", 64'(bus.flush_pending), 64'(1));
    chk("prereset.instr0", 64'(bus.out_instr[31:0]), 64'(32'h8C220004));
    #3 reset = 1'b0;
    #1;
    check_cleared("async_reset");
    bus.hold = 1'b0; bus.flush = 1'b1; bus.in_valid = 2'b11;
    @(posedge clk);
    #1;
    check_cleared("reset_dominates");
    #1 reset = 1'b1;
    model_reset();

    // Counter saturation: 20 held cycles
    for (int n = 0; n < 20; n++)
      drive(1, 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom);
    chk("sat.stall_cnt", 64'(bus.stall_cnt), 64'(exp_cnt(CMAX)));
    check_model("sat");
    drive(0, 0, 2'b00, 2'b11, 32'h1, 32'h2, 32'h3, 32'h4);
    check_model("sat_release");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit          h, f;
      logic [1:0]  k, v;
      h = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 5) == 0);
      k = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      v = 2'($urandom);
      drive(h, f, k, v, $urandom, $urandom, $urandom, $urandom);
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
